// File: rtl/cp0_core.sv
// CP0 coprocessor register file: Status, Cause, EPC, BadVAddr, Count and Compare
// with exception capture, eret handling, the interval timer and interrupt detection.
module cp0_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_we,
  input  logic [7:0]  c0_addr,
  input  logic [31:0] c0_wdata,
  input  logic        wb_ex,
  input  logic [4:0]  wb_excode,
  input  logic        wb_bd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_badvaddr,
  input  logic        eret_flush,
  input  logic [5:0]  ext_int_in,
  output logic [31:0] rdata,
  output logic [31:0] c0_epc,
  output logic        has_int,
  output logic        status_exl
);

  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  logic [7:0]  status_im;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;

  logic        wr_badvaddr;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic [31:0] count_inc;
  logic [7:0]  cause_ip;
  logic [31:0] status_word;
  logic [31:0] cause_word;

  // Write decode and derived register views
  always_comb begin
    wr_badvaddr = 1'b0;
    wr_count    = 1'b0;
    wr_compare  = 1'b0;
    wr_status   = 1'b0;
    wr_cause    = 1'b0;
    wr_epc      = 1'b0;
    if (mtc0_we) begin
      case (c0_addr)
        ADDR_BADVADDR: wr_badvaddr = 1'b1;
        ADDR_COUNT:    wr_count    = 1'b1;
        ADDR_COMPARE:  wr_compare  = 1'b1;
        ADDR_STATUS:   wr_status   = 1'b1;
        ADDR_CAUSE:    wr_cause    = 1'b1;
        ADDR_EPC:      wr_epc      = 1'b1;
        default:       wr_badvaddr = 1'b0;
      endcase
    end else begin
      wr_badvaddr = 1'b0;
    end
    count_inc   = count + 32'd1;
    // The timer interrupt shares IP7 with the top hardware line.
    cause_ip    = {cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw};
    status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
    cause_word  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'd0};
  end

  // Register read mux; reflects state before the current edge
  always_comb begin
    rdata = 32'd0;
    case (c0_addr)
      ADDR_BADVADDR: rdata = badvaddr;
      ADDR_COUNT:    rdata = count;
      ADDR_COMPARE:  rdata = compare;
      ADDR_STATUS:   rdata = status_word;
      ADDR_CAUSE:    rdata = cause_word;
      ADDR_EPC:      rdata = c0_epc;
      default:       rdata = 32'd0;
    endcase
  end

  assign has_int = (|(cause_ip & status_im)) & status_ie & ~status_exl;

  // Status, Cause, EPC and BadVAddr updates: wb_ex beats eret beats mtc0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im     <= 8'd0;
      status_ie     <= 1'b0;
      status_exl    <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip_hw   <= 6'd0;
      cause_ip_sw   <= 2'd0;
      cause_exccode <= 5'd0;
      c0_epc        <= 32'd0;
      badvaddr      <= 32'd0;
    end else begin
      cause_ip_hw <= ext_int_in;
      if (wr_status) begin
        status_im <= c0_wdata[15:8];
        status_ie <= c0_wdata[0];
      end
      if (wr_cause) begin
        cause_ip_sw <= c0_wdata[9:8];
      end
      if (wb_ex) begin
        status_exl    <= 1'b1;
        cause_exccode <= wb_excode;
        // Nested exceptions keep the original return point.
        if (!status_exl) begin
          cause_bd <= wb_bd;
          c0_epc   <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
        end
      end else if (eret_flush) begin
        status_exl <= 1'b0;
        if (wr_epc) begin
          c0_epc <= c0_wdata;
        end
      end else begin
        if (wr_status) begin
          status_exl <= c0_wdata[1];
        end
        if (wr_epc) begin
          c0_epc <= c0_wdata;
        end
      end
      if (wb_ex && ((wb_excode == 5'h04) || (wb_excode == 5'h05))) begin
        badvaddr <= wb_badvaddr;
      end else if (wr_badvaddr) begin
        badvaddr <= c0_wdata;
      end
    end
  end

  // Count runs at half the clock rate; TI latches on Count reaching Compare
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick     <= 1'b0;
      count    <= 32'd0;
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wr_count) begin
        count <= c0_wdata;
      end else if (tick) begin
        count <= count_inc;
      end
      if (wr_compare) begin
        compare  <= c0_wdata;
        cause_ti <= 1'b0;
      end else if (tick && !wr_count && (count_inc == compare)) begin
        cause_ti <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_core.sv
// Self-checking bench for cp0_core: directed scenarios plus randomized traffic
// compared against a word-level behavioural model of the CP0 registers.
module tb_cp0_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mtc0_we = 1'b0;
  logic [7:0]  c0_addr = 8'd0;
  logic [31:0] c0_wdata = 32'd0;
  logic        wb_ex = 1'b0;
  logic [4:0]  wb_excode = 5'd0;
  logic        wb_bd = 1'b0;
  logic [31:0] wb_pc = 32'd0;
  logic [31:0] wb_badvaddr = 32'd0;
  logic        eret_flush = 1'b0;
  logic [5:0]  ext_int_in = 6'd0;
  logic [31:0] rdata;
  logic [31:0] c0_epc;
  logic        has_int;
  logic        status_exl;

  int tests = 0;
  int fails = 0;

  // Model state: Status and Cause as whole words (Cause without the live IP7..IP2 lines)
  logic [31:0] m_status, m_cause, m_count, m_compare, m_epc, m_bva;
  logic        m_tick;
  logic [5:0]  m_ext;

  cp0_core dut (
    .clk(clk), .resetn(resetn), .mtc0_we(mtc0_we), .c0_addr(c0_addr),
    .c0_wdata(c0_wdata), .wb_ex(wb_ex), .wb_excode(wb_excode), .wb_bd(wb_bd),
    .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr), .eret_flush(eret_flush),
    .ext_int_in(ext_int_in), .rdata(rdata), .c0_epc(c0_epc), .has_int(has_int),
    .status_exl(status_exl)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_status = 32'h0040_0000; m_cause = 32'd0; m_count = 32'd0; m_compare = 32'd0;
    m_epc = 32'd0; m_bva = 32'd0; m_tick = 1'b0; m_ext = 6'd0;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] cv;
    cv = m_cause | ({26'd0, m_ext} << 10) | ({31'd0, m_cause[30]} << 15);
    case (a)
      8'h40: return m_bva;
      8'h48: return m_count;
      8'h58: return m_compare;
      8'h60: return m_status;
      8'h68: return cv;
      8'h70: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_has_int();
    logic [31:0] cv;
    cv = m_read(8'h68);
    return ((cv[15:8] & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[1];
  endfunction

  // Advance one clock: compute next model state from the current inputs, then edge.
  task automatic step();
    logic [31:0] s, c, cnt, cmp, e, b;
    s = m_status; c = m_cause; cnt = m_count; cmp = m_compare; e = m_epc; b = m_bva;
    if (mtc0_we) begin
      case (c0_addr)
        8'h40: b = c0_wdata;
        8'h48: cnt = c0_wdata;
        8'h58: cmp = c0_wdata;
        8'h60: s = 32'h0040_0000 | (c0_wdata & 32'h0000_FF03);
        8'h68: c = (c & ~32'h0000_0300) | (c0_wdata & 32'h0000_0300);
        8'h70: e = c0_wdata;
        default: ;
      endcase
    end
    if (!(mtc0_we && c0_addr == 8'h48) && m_tick) begin
      cnt = m_count + 32'd1;
      if (cnt == m_compare) c[30] = 1'b1;
    end
    if (mtc0_we && c0_addr == 8'h58) c[30] = 1'b0;
    if (wb_ex) begin
      s[1] = 1'b1;
      c[6:2] = wb_excode;
      e = m_epc;
      if (!m_status[1]) begin
        c[31] = wb_bd;
        e = wb_bd ? wb_pc - 32'd4 : wb_pc;
      end
      if (wb_excode == 5'h04 || wb_excode == 5'h05) b = wb_badvaddr;
    end else if (eret_flush) begin
      s[1] = 1'b0;
    end
    @(posedge clk);
    if (!resetn) begin
      m_reset();
    end else begin
      m_status = s; m_cause = c; m_count = cnt; m_compare = cmp; m_epc = e; m_bva = b;
      m_tick = ~m_tick; m_ext = ext_int_in;
    end
    #1;
  endtask

  task automatic idle();
    mtc0_we = 1'b0; c0_addr = 8'd0; c0_wdata = 32'd0; wb_ex = 1'b0; wb_excode = 5'd0;
    wb_bd = 1'b0; wb_pc = 32'd0; wb_badvaddr = 32'd0; eret_flush = 1'b0; ext_int_in = 6'd0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    idle();
    mtc0_we = 1'b1; c0_addr = a; c0_wdata = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [7:0] addrs [8];
    logic [31:0] exp;
    addrs = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00, 8'hFF};
    idle(); m_reset(); resetn = 1'b0;
    step(); step();
    foreach (addrs[i]) begin
      c0_addr = addrs[i]; #1;
      exp = (addrs[i] == 8'h60) ? 32'h0040_0000 : 32'd0;
      tests++;
      if (rdata !== exp) begin fails++; $display("FAIL reset_rd[%h]: got %h want %h", addrs[i], rdata, exp); end
    end
    tests++;
    if ({c0_epc, status_exl, has_int} !== 34'd0) begin
      fails++; $display("FAIL reset_out: epc %h exl %b int %b want 0", c0_epc, status_exl, has_int);
    end
  endtask

  task automatic test_count_start();
    idle(); resetn = 1'b1; c0_addr = 8'h48;
    step();
    tests++;
    if (rdata !== 32'd0) begin fails++; $display("FAIL count_edge1: got %h want 0", rdata); end
    step();
    tests++;
    if (rdata !== 32'd1) begin fails++; $display("FAIL count_edge2: got %h want 1", rdata); end
  endtask

  task automatic test_status_write();
    mtc0(8'h60, 32'hFFFF_FFFF);
    c0_addr = 8'h60; #1;
    tests++;
    if (rdata !== 32'h0040_FF03 || has_int !== 1'b0) begin
      fails++; $display("FAIL status_wr: got %h int %b want 0040ff03 int 0", rdata, has_int);
    end
  endtask

  task automatic test_exception();
    mtc0(8'h60, 32'd0);
    wb_ex = 1'b1; wb_excode = 5'h04; wb_bd = 1'b1; wb_pc = 32'hBFC0_0104; wb_badvaddr = 32'h3;
    step(); idle();
    tests++;
    if (c0_epc !== 32'hBFC0_0100 || status_exl !== 1'b1) begin
      fails++; $display("FAIL exc1_epc: epc %h exl %b want bfc00100 1", c0_epc, status_exl);
    end
    c0_addr = 8'h68; #1;
    tests++;
    if ((rdata & 32'h8000_007C) !== 32'h8000_0010) begin
      fails++; $display("FAIL exc1_cause: got %h want bd=1 exccode=4", rdata);
    end
    c0_addr = 8'h40; #1;
    tests++;
    if (rdata !== 32'h0000_0003) begin fails++; $display("FAIL exc1_bva: got %h want 3", rdata); end
    wb_ex = 1'b1; wb_excode = 5'h0C; wb_bd = 1'b0; wb_pc = 32'h200; wb_badvaddr = 32'hDEAD_0000;
    step(); idle();
    c0_addr = 8'h68; #1;
    tests++;
    if (c0_epc !== 32'hBFC0_0100 || (rdata & 32'h8000_007C) !== 32'h8000_0030) begin
      fails++; $display("FAIL exc2_nested: epc %h cause %h want bfc00100 bd=1 exccode=c", c0_epc, rdata);
    end
    c0_addr = 8'h40; #1;
    tests++;
    if (rdata !== 32'h0000_0003) begin fails++; $display("FAIL exc2_bva: got %h want 3", rdata); end
  endtask

  task automatic test_eret();
    wb_ex = 1'b1; eret_flush = 1'b1;
    step(); idle();
    tests++;
    if (status_exl !== 1'b1) begin fails++; $display("FAIL eret_vs_ex: exl %b want 1", status_exl); end
    eret_flush = 1'b1;
    step(); idle();
    tests++;
    if (status_exl !== 1'b0) begin fails++; $display("FAIL eret_alone: exl %b want 0", status_exl); end
  endtask

  task automatic test_timer();
    for (int k = 0; k < 2 && m_tick != 1'b0; k++) step();
    mtc0(8'h58, 32'd10);
    mtc0(8'h48, 32'd8);
    mtc0(8'h60, 32'h0000_8001);
    step(); step();
    c0_addr = 8'h68; #1;
    tests++;
    if (rdata[30] !== 1'b0 || has_int !== 1'b0) begin
      fails++; $display("FAIL timer_early: ti %b int %b want 0 0", rdata[30], has_int);
    end
    step();
    c0_addr = 8'h68; #1;
    tests++;
    if (rdata[30] !== 1'b1 || has_int !== 1'b1) begin
      fails++; $display("FAIL timer_fire: ti %b int %b want 1 1", rdata[30], has_int);
    end
    mtc0(8'h58, 32'd20);
    c0_addr = 8'h68; #1;
    tests++;
    if (rdata[30] !== 1'b0 || has_int !== 1'b0) begin
      fails++; $display("FAIL timer_clear: ti %b int %b want 0 0", rdata[30], has_int);
    end
    mtc0(8'hFF, 32'h1234_5678);
    c0_addr = 8'h58; #1;
    tests++;
    if (rdata !== 32'd20) begin fails++; $display("FAIL unmapped_wr: compare %h want 14", rdata); end
    mtc0(8'h48, 32'hFFFF_FFFF);
    step(); step();
    c0_addr = 8'h48; #1;
    tests++;
    if (rdata !== 32'd0) begin fails++; $display("FAIL count_wrap: got %h want 0", rdata); end
  endtask

  task automatic test_ext_int();
    mtc0(8'h60, 32'h0000_0401);
    ext_int_in = 6'b000001;
    step();
    c0_addr = 8'h68; #1;
    tests++;
    if (rdata[10] !== 1'b1 || has_int !== 1'b1) begin
      fails++; $display("FAIL ext_int_set: ip2 %b int %b want 1 1", rdata[10], has_int);
    end
    ext_int_in = 6'd0;
    step();
    #1;
    tests++;
    if (rdata[10] !== 1'b0 || has_int !== 1'b0) begin
      fails++; $display("FAIL ext_int_clr: ip2 %b int %b want 0 0", rdata[10], has_int);
    end
  endtask

  task automatic test_random();
    logic [7:0] amap [6];
    int r;
    logic [31:0] exp;
    amap = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70};
    for (int n = 0; n < 400; n++) begin
      idle();
      wb_ex = ($urandom_range(0, 7) == 0);
      eret_flush = ($urandom_range(0, 7) == 0);
      mtc0_we = !wb_ex && ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 6);
      c0_addr = (r == 6) ? 8'($urandom) : amap[r];
      c0_wdata = $urandom;
      if (c0_addr == 8'h58) c0_wdata = m_count + 32'($urandom_range(1, 6));
      if (c0_addr == 8'h60 && $urandom_range(0, 1) == 1) c0_wdata[1] = 1'b0;
      wb_excode = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
      wb_bd = 1'($urandom); wb_pc = $urandom; wb_badvaddr = $urandom;
      ext_int_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      #1;
      exp = m_read(c0_addr);
      tests++;
      if (rdata !== exp || has_int !== m_has_int()) begin
        fails++; $display("FAIL rand_rd[%0d] @%h: got %h/%b want %h/%b", n, c0_addr, rdata, has_int, exp, m_has_int());
      end
      step();
      tests++;
      if (c0_epc !== m_epc || status_exl !== m_status[1] || has_int !== m_has_int()) begin
        fails++; $display("FAIL rand_state[%0d]: epc %h exl %b int %b want %h %b %b",
                          n, c0_epc, status_exl, has_int, m_epc, m_status[1], m_has_int());
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    mtc0(8'h70, 32'h1234_5678);
    mtc0(8'h58, m_count + 32'd2);
    mtc0(8'h60, 32'h0000_0401);
    ext_int_in = 6'b000001; c0_addr = 8'h48;
    step(); step();
    tests++;
    if (has_int !== 1'b1 || c0_epc !== 32'h1234_5678) begin
      fails++; $display("FAIL arst_pre: int %b epc %h want 1 12345678", has_int, c0_epc);
    end
    #2 resetn = 1'b0;
    #1;
    tests++;
    if (c0_epc !== 32'd0 || status_exl !== 1'b0 || has_int !== 1'b0 || rdata !== 32'd0) begin
      fails++; $display("FAIL arst_now: epc %h exl %b int %b count %h want 0", c0_epc, status_exl, has_int, rdata);
    end
    c0_addr = 8'h68; #1;
    tests++;
    if (rdata !== 32'd0) begin fails++; $display("FAIL arst_cause: got %h want 0", rdata); end
    idle();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count_start();
    test_status_write();
    test_exception();
    test_eret();
    test_timer();
    test_ext_int();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
